vx_sched_branch_checker: RTL

Checker that sits directly downstream of the scheduler's branch-feedback path. Each cycle it samples ALU branch resolutions and records, per warp, the PC the scheduler must install. It then watches the scheduler's per-warp PC vector and checks that the recorded PC appears within a bounded window. It reports pass/fail events and running counts for the verification environment and coverage.

---
 rtl/vx_sched_branch_checker_if.sv | 32 +++
 rtl/vx_sched_branch_checker.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/vx_sched_branch_checker_if.sv
// rtl/vx_sched_branch_checker_if.sv - branch-resolution and warp-PC bundle observed by the branch checker
//
// Signals (all sampled every cycle, no handshake):
//   br_valid  [NUM_ALU_BLOCKS]          branch resolved, per ALU block
//   br_wid    [NUM_ALU_BLOCKS*WID_W]    warp of each branch
//   br_taken  [NUM_ALU_BLOCKS]          taken flag
//   br_target [NUM_ALU_BLOCKS*PC_BITS]  taken target
//   br_pc     [NUM_ALU_BLOCKS*PC_BITS]  PC of the branch instruction
//   warp_pcs  [NUM_WARPS*PC_BITS]       scheduler's current PC per warp
// Modports: master drives the bundle, slave (the checker) observes it.
interface vx_sched_branch_checker_if #(
  parameter int NUM_WARPS      = 4,
  parameter int NUM_ALU_BLOCKS = 2,
  parameter int PC_BITS        = 30
);
  localparam int WID_W = $clog2(NUM_WARPS);

  logic [NUM_ALU_BLOCKS-1:0]         br_valid;
  logic [NUM_ALU_BLOCKS*WID_W-1:0]   br_wid;
  logic [NUM_ALU_BLOCKS-1:0]         br_taken;
  logic [NUM_ALU_BLOCKS*PC_BITS-1:0] br_target;
  logic [NUM_ALU_BLOCKS*PC_BITS-1:0] br_pc;
  logic [NUM_WARPS*PC_BITS-1:0]      warp_pcs;

  modport master (
    output br_valid, br_wid, br_taken, br_target, br_pc, warp_pcs
  );

  modport slave (
    input br_valid, br_wid, br_taken, br_target, br_pc, warp_pcs
  );
endinterface

// File: rtl/vx_sched_branch_checker.sv
// rtl/vx_sched_branch_checker.sv - checks that resolved branch PCs reach the scheduler's warp PCs within a bounded window
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   chk_en         enable; low drops all pending checks and suppresses captures/errors
//   br_if          branch resolutions and per-warp PCs (slave modport)
//   pending        per-warp outstanding check
//   err_valid      one-cycle error pulse; err_code 0=timeout 1=overlap 2=collision
//   err_wid        lowest warp with an error that cycle
//   pass_count     saturating count of matched checks
//   fail_count     saturating count of all errors
module vx_sched_branch_checker #(
  parameter int NUM_WARPS      = 4,
  parameter int NUM_ALU_BLOCKS = 2,
  parameter int PC_BITS        = 30,
  parameter int INSTR_INC      = 2,
  parameter int MAX_LAT        = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         chk_en,
  vx_sched_branch_checker_if.slave     br_if,
  output logic [NUM_WARPS-1:0]         pending,
  output logic                         err_valid,
  output logic [1:0]                   err_code,
  output logic [$clog2(NUM_WARPS)-1:0] err_wid,
  output logic [15:0]                  pass_count,
  output logic [15:0]                  fail_count
);
  localparam int WID_W = $clog2(NUM_WARPS);

  logic [PC_BITS-1:0] exp_q [NUM_WARPS];
  logic [3:0]         cnt_q [NUM_WARPS];
  logic [PC_BITS-1:0] exp_d [NUM_WARPS];
  logic [3:0]         cnt_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] pend_d;

  // Per-warp capture decode results
  logic [NUM_WARPS-1:0] cap;
  logic [NUM_WARPS-1:0] coll;
  logic [PC_BITS-1:0]   cap_exp [NUM_WARPS];

  // Per-warp check results against the entry held before this edge
  logic [NUM_WARPS-1:0] match;
  logic [NUM_WARPS-1:0] tmo;
  logic [NUM_WARPS-1:0] ovl;

  logic [7:0]       n_pass;
  logic [7:0]       n_err;
  logic             e_hit;
  logic [1:0]       e_code;
  logic [WID_W-1:0] e_wid;

  // Walk blocks from highest to lowest so the lowest-index hit is the last
  // one written; any second hit on the same warp marks a collision.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      cap[w]     = 1'b0;
      coll[w]    = 1'b0;
      cap_exp[w] = '0;
      for (int b = NUM_ALU_BLOCKS - 1; b >= 0; b--) begin
        if (br_if.br_valid[b] && (br_if.br_wid[b*WID_W +: WID_W] == WID_W'(w))) begin
          if (cap[w]) coll[w] = 1'b1;
          cap[w] = 1'b1;
          if (br_if.br_taken[b])
            cap_exp[w] = br_if.br_target[b*PC_BITS +: PC_BITS];
          else
            cap_exp[w] = br_if.br_pc[b*PC_BITS +: PC_BITS] + PC_BITS'(INSTR_INC);
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      match[w] = pending[w] && (br_if.warp_pcs[w*PC_BITS +: PC_BITS] == exp_q[w]);
      tmo[w]   = pending[w] && !match[w] && (cnt_q[w] == 4'd1);
      // A replacing capture only counts as overlap if the old entry was still live
      ovl[w]   = cap[w] && pending[w] && !match[w] && !tmo[w];
    end
  end

  always_comb begin
    pend_d = pending;
    exp_d  = exp_q;
    cnt_d  = cnt_q;
    n_pass = '0;
    n_err  = '0;
    e_hit  = 1'b0;
    e_code = 2'd0;
    e_wid  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (!chk_en) begin
        pend_d[w] = 1'b0;
      end else begin
        n_pass = n_pass + 8'(match[w]);
        n_err  = n_err + 8'(tmo[w]) + 8'(ovl[w]) + 8'(coll[w]);
        if (!e_hit && (tmo[w] || ovl[w] || coll[w])) begin
          e_hit  = 1'b1;
          e_wid  = WID_W'(w);
          e_code = tmo[w] ? 2'd0 : (ovl[w] ? 2'd1 : 2'd2);
        end
        if (cap[w]) begin
          pend_d[w] = 1'b1;
          exp_d[w]  = cap_exp[w];
          cnt_d[w]  = 4'(MAX_LAT);
        end else if (match[w] || tmo[w]) begin
          pend_d[w] = 1'b0;
        end else if (pending[w]) begin
          cnt_d[w] = cnt_q[w] - 4'd1;
        end
      end
    end
  end

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [7:0] n);
    logic [16:0] s;
    s = {1'b0, a} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      err_valid  <= 1'b0;
      err_code   <= 2'd0;
      err_wid    <= '0;
      pass_count <= '0;
      fail_count <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        exp_q[w] <= '0;
        cnt_q[w] <= '0;
      end
    end else begin
      pending    <= pend_d;
      err_valid  <= e_hit;
      err_code   <= e_code;
      err_wid    <= e_wid;
      pass_count <= sat_add(pass_count, n_pass);
      fail_count <= sat_add(fail_count, n_err);
      for (int w = 0; w < NUM_WARPS; w++) begin
        exp_q[w] <= exp_d[w];
        cnt_q[w] <= cnt_d[w];
      end
    end
  end
endmodule
